spi_rom_responder: RTL and testbench
====================================

// Module: spi_rom_responder
// PURPOSE
//  SPI Mode-0 responder that emulates a serial flash ROM for READ (03h), serving bytes from an
//  external synchronous byte memory. Target end of our SPI ROM-read initiators, for FPGA bring-up
//  and closed-loop sims. SCLK/CS/MOSI are oversampled in the system clock domain (single clock).
// PARAMETERS
//  ADDR_BITS    10  memory address width; only low ADDR_BITS of the 24-bit SPI address are used
//  SYNC_STAGES  2   input synchroniser depth for spi_cs/spi_sclk/spi_mosi (>=2)
// PORTS
//  clk       in   1          system clock; SCLK high and low phases each >= SYNC_STAGES+3 clk cycles
//  reset     in   1          asynchronous, active-high
//  spi_cs    in   1          chip select, ACTIVE HIGH (parent inverts for active-low hosts)
//  spi_sclk  in   1          SPI clock from initiator
//  spi_mosi  in   1          command/address bits, MSB first, sampled on SCLK rise
//  spi_miso  out  1          data bits, MSB first, changed on SCLK fall
//  mem_addr  out  ADDR_BITS  byte address to memory
//  mem_rd    out  1          1-cycle read strobe; mem_data valid exactly 1 clk later
//  mem_data  in   8          read data
//  busy      out  1          1 while a recognised command is in progress
//  cmd_err   out  1          1-cycle pulse when an unsupported opcode completes
// BEHAVIOUR
//  - Reset: spi_miso=0, mem_addr=0, mem_rd=0, busy=0, cmd_err=0, state=IDLE, sync flops=0.
//  - Sync all three inputs through SYNC_STAGES flops; rise/fall = synced sclk vs 1-clk-delayed copy.
//  - States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> [DUMMY] -> DATA; IGNORE for unknown opcode.
//    IDLE->CMD on synced cs rising, bit counter cleared. CMD: opcode 03h -> ADDR; else assert
//    cmd_err for 1 clk -> IGNORE. ADDR: shift 24 bits; after 24th rise latch addr[ADDR_BITS-1:0]
//    into mem_addr, pulse mem_rd next clk, load shift reg from mem_data the clk after -> DATA.
//  - DATA: on each SCLK fall drive shreg[7] on spi_miso, shift left. First fall after ADDR drives
//    bit 7 of byte at start address. On fall driving bit 0: mem_addr <= mem_addr+1 (wraps mod
//    2^ADDR_BITS, e.g. 0x3FF->0x000), pulse mem_rd; next byte loaded before the following fall.
//    Streams indefinitely while cs is high.
//  - Synced cs low in any state -> IDLE next clk, spi_miso=0, busy=0, bit counter cleared;
//    partial command/address discarded. No mem_rd issued after cs drop.
//  - spi_miso=0 in IDLE/CMD/ADDR/DUMMY/IGNORE (never tristated). busy=1 in ADDR/DUMMY/DATA.
//  - cs rise and sclk edge in same clk: cs handled first; edge is ignored (Mode 0: SCLK idles low).
//  - Reset mid-transaction: immediate return to reset values; next cs rise starts cleanly.
// CONFIGURATION
//  SPI_FAST_READ_EN defined: opcode 0Bh (FAST READ) also accepted; after ADDR, DUMMY state
//   counts 8 SCLK rises (MOSI ignored); fetch runs during DUMMY, first data bit on fall after 8th.
//  Undefined: 0Bh treated as unsupported (cmd_err pulse, IGNORE).
// STRUCTURE
//  Shared package/header: opcode constants SPI_CMD_READ=8'h03, SPI_CMD_FAST_READ=8'h0B,
//   state encodings, SPI_ADDR_LEN=24, SPI_CMD_LEN=8.
//  One sub-module: spi_edge_sync (N-stage synchroniser + rise/fall detect), one instance per input
//   (edge outputs used for sclk and cs only).
// TESTING
//  1 mem[i]=i^8'hA5; cs, 03h, addr 000010h, 32 clocks -> miso bytes B5,B4,B7,B6; mem_rd per byte.
//  2 Start addr 0003FEh, read 4 bytes -> data from 3FE,3FF,000,001 (wrap), mem_addr ends 002.
//  3 Opcode 9Fh -> cmd_err one 1-clk pulse, busy=0, miso=0 for 32 further clocks; next 03h ok.
//  4 cs dropped after 12 address bits -> IDLE, no mem_rd; new 03h/000000h read returns mem[0].
//  5 reset asserted mid-DATA -> miso=0, busy=0 same cycle; post-reset read of 000020h correct.
//  6 0Bh, addr 000004h, 8 dummy -> mem[4],mem[5] with SPI_FAST_READ_EN; cmd_err pulse without.

Source files
------------

// File: rtl/spi_rom_responder_pkg.sv
// Shared constants and FSM state encoding for the SPI ROM-read responder.
// The FAST READ (0Bh) opcode is only accepted when SPI_FAST_READ_EN is defined.
package spi_rom_responder_pkg;

  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

  localparam int SPI_CMD_LEN   = 8;
  localparam int SPI_ADDR_LEN  = 24;
  localparam int SPI_DUMMY_LEN = 8;
  localparam int SPI_BYTE_LEN  = 8;

  // Wide enough to count the longest phase (24 address bits).
  localparam int BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// N-stage input synchroniser with rise/fall detection against a 1-clk-delayed
// copy of the synchronised level.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its predecessor's value from before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI Mode-0 responder emulating a serial flash for READ (03h), streaming bytes
// from an external synchronous memory. Define SPI_FAST_READ_EN to accept 0Bh.
module spi_rom_responder
  import spi_rom_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic                 busy,
  output logic                 cmd_err
);

  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .i_d   (spi_cs),
    .o_q   (w_cs),
    .o_rise(w_cs_rise),
    .o_fall(w_cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .i_d   (spi_sclk),
    .o_q   (w_sclk),
    .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .i_d   (spi_mosi),
    .o_q   (w_mosi),
    .o_rise(w_mosi_rise),
    .o_fall(w_mosi_fall)
  );

  // Only the cs rise and the sclk edges drive the FSM; cs is otherwise used as a level.
  logic w_unused_edges;
  assign w_unused_edges = &{1'b0, w_cs_fall, w_sclk, w_mosi_rise, w_mosi_fall};

  state_e                 r_state;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [7:0]             r_cmd_sr;
  logic [ADDR_BITS-1:0]   r_addr_sr;
  logic [7:0]             r_shreg;
  logic                   r_fast;
  logic                   r_rd_pend;
  logic                   r_load_pend;
  logic                   r_miso;
  logic [ADDR_BITS-1:0]   r_mem_addr;
  logic                   r_mem_rd;
  logic                   r_busy;
  logic                   r_cmd_err;

  logic [7:0]           w_opcode_next;
  logic [ADDR_BITS-1:0] w_addr_next;
  logic                 w_op_fast;
  logic                 w_op_ok;

  assign w_opcode_next = {r_cmd_sr[6:0], w_mosi};
  assign w_addr_next   = {r_addr_sr[ADDR_BITS-2:0], w_mosi};

`ifdef SPI_FAST_READ_EN
  assign w_op_fast = (w_opcode_next == SPI_CMD_FAST_READ);
`else
  assign w_op_fast = 1'b0;
`endif
  assign w_op_ok = (w_opcode_next == SPI_CMD_READ) || w_op_fast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cmd_sr    <= '0;
      r_addr_sr   <= '0;
      r_shreg     <= '0;
      r_fast      <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_load_pend <= 1'b0;
      r_miso      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err   <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_load_pend <= 1'b0;

      if (!w_cs && (r_state != ST_IDLE)) begin
        // Deselect aborts everything, including a fetch still in flight.
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_busy    <= 1'b0;
        r_rd_pend <= 1'b0;
      end else begin
        if (r_rd_pend) begin
          r_mem_rd  <= 1'b1;
          r_rd_pend <= 1'b0;
        end
        r_load_pend <= r_mem_rd;

        case (r_state)
          ST_IDLE: begin
            if (w_cs_rise) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
            end
          end

          ST_CMD: begin
            if (w_sclk_rise) begin
              r_cmd_sr <= w_opcode_next;
              if (r_bit_cnt == BIT_CNT_W'(SPI_CMD_LEN - 1)) begin
                r_bit_cnt <= '0;
                if (w_op_ok) begin
                  r_state <= ST_ADDR;
                  r_fast  <= w_op_fast;
                  r_busy  <= 1'b1;
                end else begin
                  r_state   <= ST_IGNORE;
                  r_cmd_err <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end

          ST_ADDR: begin
            if (w_sclk_rise) begin
              r_addr_sr <= w_addr_next;
              if (r_bit_cnt == BIT_CNT_W'(SPI_ADDR_LEN - 1)) begin
                r_bit_cnt  <= '0;
                r_mem_addr <= w_addr_next;
                r_rd_pend  <= 1'b1;
                r_state    <= r_fast ? ST_DUMMY : ST_DATA;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end

          ST_DUMMY: begin
            if (w_sclk_rise) begin
              if (r_bit_cnt == BIT_CNT_W'(SPI_DUMMY_LEN - 1)) begin
                r_bit_cnt <= '0;
                r_state   <= ST_DATA;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (w_sclk_fall) begin
              r_miso  <= r_shreg[7];
              r_shreg <= {r_shreg[6:0], 1'b0};
              if (r_bit_cnt == BIT_CNT_W'(SPI_BYTE_LEN - 1)) begin
                // Prefetch the next byte while bit 0 is on the wire.
                r_bit_cnt  <= '0;
                r_mem_addr <= r_mem_addr + 1'b1;
                r_mem_rd   <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end

          ST_IGNORE: begin
            r_busy <= 1'b0;
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase

        // SCLK half-periods guarantee no fall lands on the load cycle.
        if (r_load_pend) begin
          r_shreg <= mem_data;
        end
      end
    end
  end

  assign spi_miso = r_miso;
  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign busy     = r_busy;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed, table-driven bench for spi_rom_responder with a registered byte
// memory model holding mem[i] = i[7:0] ^ 8'hA5.
module tb_spi_rom_responder;

  localparam int ADDR_BITS   = 10;
  localparam int SYNC_STAGES = 2;
  localparam int HP          = 6;   // SCLK half-period in clk cycles
  localparam int NVEC        = 7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 spi_cs;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_data;
  logic                 busy;
  logic                 cmd_err;

  always #5 clk = ~clk;

  spi_rom_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .spi_cs  (spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_data(mem_data),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  logic [7:0] mem [1 << ADDR_BITS];

  initial begin
    mem_data = 8'h00;
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 8'(i) ^ 8'hA5;
  end

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // Free-running event counters; tests take differences across a transaction.
  int rd_cnt  = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd)  rd_cnt  <= rd_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]           op;
    logic [23:0]          addr;
    int                   nbytes;
    int                   ndummy;
    logic                 exp_err;
    logic [31:0]          exp_bytes;  // first byte in [31:24]
    logic [ADDR_BITS-1:0] exp_end;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    tick(HP);
    m = spi_miso;
    spi_sclk = 1'b1;
    tick(HP);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic spi_start();
    spi_cs = 1'b1;
    tick(HP);
  endtask

  task automatic spi_stop();
    tick(HP);
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int         rd0, err0;
    logic [7:0] rx;
    logic       m;
    logic       seen_miso, seen_busy;
    logic [31:0] exp_b;
    rd0  = rd_cnt;
    err0 = err_cnt;
    spi_start();
    spi_byte(v.op, rx);
    if (v.exp_err) begin
      seen_miso = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 32; i++) begin
        spi_bit(1'b1, m);
        seen_miso |= m;
        seen_busy |= busy;
      end
      check({tag, "_ign_miso"}, 32'(seen_miso), 32'd0);
      check({tag, "_ign_busy"}, 32'(seen_busy), 32'd0);
      check({tag, "_err_pulses"}, 32'(err_cnt - err0), 32'd1);
      check({tag, "_ign_rd"}, 32'(rd_cnt - rd0), 32'd0);
      spi_stop();
    end else begin
      for (int i = 2; i >= 0; i--) begin
        spi_byte(v.addr[i*8 +: 8], rx);
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < v.ndummy; i++) spi_bit(1'b0, m);
      exp_b = v.exp_bytes;
      for (int b = 0; b < v.nbytes; b++) begin
        spi_byte(8'h00, rx);
        check($sformatf("%s_byte%0d", tag, b), 32'(rx), 32'(exp_b[31:24]));
        exp_b = exp_b << 8;
      end
      spi_stop();
      check({tag, "_rd_cnt"}, 32'(rd_cnt - rd0), 32'(v.nbytes + 1));
      check({tag, "_end_addr"}, 32'(mem_addr), 32'(v.exp_end));
      check({tag, "_no_err"}, 32'(err_cnt - err0), 32'd0);
    end
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_miso"}, 32'(spi_miso), 32'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] rx;
    logic       m;
    int         rd0;
    vec_t       v;

    vecs[0] = '{8'h03, 24'h000010, 4, 0, 1'b0, 32'hB5B4B7B6, 10'h014};
    vecs[1] = '{8'h03, 24'h0003FE, 4, 0, 1'b0, 32'h5B5AA5A4, 10'h002};
    vecs[2] = '{8'h9F, 24'h000000, 0, 0, 1'b1, 32'h0,        10'h000};
    vecs[3] = '{8'h03, 24'h000000, 1, 0, 1'b0, 32'hA5000000, 10'h001};
    vecs[4] = '{8'h03, 24'hABC155, 2, 0, 1'b0, 32'hF0F30000, 10'h157};
`ifdef SPI_FAST_READ_EN
    vecs[5] = '{8'h0B, 24'h000004, 2, 8, 1'b0, 32'hA1A00000, 10'h006};
`else
    vecs[5] = '{8'h0B, 24'h000004, 0, 0, 1'b1, 32'h0,        10'h000};
`endif
    vecs[6] = '{8'h03, 24'h0003FF, 1, 0, 1'b0, 32'h5A000000, 10'h000};

    reset    = 1'b1;
    spi_cs   = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    tick(3);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rd",   32'(mem_rd),   32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_err",  32'(cmd_err),  32'd0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Deselect partway through the address: no fetch, then a clean read.
    rd0 = rd_cnt;
    spi_start();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, m);
    spi_stop();
    check("abort_rd", 32'(rd_cnt - rd0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    v = '{8'h03, 24'h000000, 1, 0, 1'b0, 32'hA5000000, 10'h001};
    run_vec(v, "post_abort");

    // Reset in the middle of the data phase.
    spi_start();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
    tick(4);
    check("mid_miso_bit4", 32'(spi_miso), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_miso", 32'(spi_miso), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    spi_cs = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);
    v = '{8'h03, 24'h000020, 2, 0, 1'b0, 32'h85840000, 10'h022};
    run_vec(v, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
